// File: rtl/wb_port_arbiter_if.sv
// Writeback port bundle between the two writeback requesters and the register-file write arbiter.
// The master side drives the requests; the slave side is the arbiter.
interface wb_port_arbiter_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned CNT_W  = 8
) ();
   logic              stall_i;
   logic              req0_valid_i;
   logic [ADDR_W-1:0] req0_addr_i;
   logic [DATA_W-1:0] req0_data_i;
   logic              req0_ready_o;
   logic              req1_valid_i;
   logic [ADDR_W-1:0] req1_addr_i;
   logic [DATA_W-1:0] req1_data_i;
   logic              req1_ready_o;
   logic              sel_o;
   logic              wr_en_o;
   logic [ADDR_W-1:0] wr_addr_o;
   logic [DATA_W-1:0] wr_data_o;
   logic [CNT_W-1:0]  conflict_cnt_o;

   modport master (
      output stall_i,
      output req0_valid_i, req0_addr_i, req0_data_i,
      output req1_valid_i, req1_addr_i, req1_data_i,
      input  req0_ready_o, req1_ready_o,
      input  sel_o, wr_en_o, wr_addr_o, wr_data_o, conflict_cnt_o
   );

   modport slave (
      input  stall_i,
      input  req0_valid_i, req0_addr_i, req0_data_i,
      input  req1_valid_i, req1_addr_i, req1_data_i,
      output req0_ready_o, req1_ready_o,
      output sel_o, wr_en_o, wr_addr_o, wr_data_o, conflict_cnt_o
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (req0) and load (req1)
// writebacks; registers the winning write and counts conflict cycles for perf debug.
module wb_port_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned CNT_W  = 8
) (
   input logic             clk_i,
   input logic             rst_i,
   wb_port_arbiter_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              last_grant_r;
   logic              sel_r;
   logic              wr_en_r;
   logic [ADDR_W-1:0] wr_addr_r;
   logic [DATA_W-1:0] wr_data_r;
   logic [CNT_W-1:0]  conflict_cnt_r;

   logic              gnt_valid;
   logic              gnt_idx;
   logic [ADDR_W-1:0] gnt_addr;
   logic [DATA_W-1:0] gnt_data;
   logic              conflict;

   // Grant decision depends only on valids, stall and the previous winner.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = 1'b0;
      if (!bus.stall_i) begin
         unique case ({bus.req1_valid_i, bus.req0_valid_i})
            2'b01:   begin gnt_valid = 1'b1; gnt_idx = 1'b0;          end
            2'b10:   begin gnt_valid = 1'b1; gnt_idx = 1'b1;          end
            2'b11:   begin gnt_valid = 1'b1; gnt_idx = ~last_grant_r; end
            default: begin gnt_valid = 1'b0; gnt_idx = 1'b0;          end
         endcase
      end
   end

   assign gnt_addr = gnt_idx ? bus.req1_addr_i : bus.req0_addr_i;
   assign gnt_data = gnt_idx ? bus.req1_data_i : bus.req0_data_i;
   assign conflict = bus.req0_valid_i & bus.req1_valid_i & ~bus.stall_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         last_grant_r   <= 1'b1;
         sel_r          <= 1'b0;
         wr_en_r        <= 1'b0;
         wr_addr_r      <= '0;
         wr_data_r      <= '0;
         conflict_cnt_r <= '0;
      end else begin
         wr_en_r <= 1'b0;
         if (gnt_valid) begin
            sel_r        <= gnt_idx;
            wr_addr_r    <= gnt_addr;
            wr_data_r    <= gnt_data;
            // Register $0 is hardwired: accept the request but suppress the write.
            wr_en_r      <= (gnt_addr != '0);
            last_grant_r <= gnt_idx;
         end
         if (conflict && (conflict_cnt_r != CNT_MAX)) begin
            conflict_cnt_r <= conflict_cnt_r + CNT_W'(1);
         end
      end
   end

   assign bus.req0_ready_o   = gnt_valid & ~gnt_idx;
   assign bus.req1_ready_o   = gnt_valid &  gnt_idx;
   assign bus.sel_o          = sel_r;
   assign bus.wr_en_o        = wr_en_r;
   assign bus.wr_addr_o      = wr_addr_r;
   assign bus.wr_data_o      = wr_data_r;
   assign bus.conflict_cnt_o = conflict_cnt_r;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized holding requesters,
// all checked against a transaction-level reference model.
module tb_wb_port_arbiter;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned CNT_W  = 8;
   localparam int CNT_SAT = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wb_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

   wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: who won last, and what the write port should show.
   int          m_last;
   logic        m_en;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   int          m_sel;
   int          m_cnt;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_last = 1; m_en = 1'b0; m_addr = '0; m_data = '0; m_sel = 0; m_cnt = 0;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".wr_en"},   64'(bus.wr_en_o),        64'(m_en));
      check({tag, ".wr_addr"}, 64'(bus.wr_addr_o),      64'(m_addr));
      check({tag, ".wr_data"}, 64'(bus.wr_data_o),      64'(m_data));
      check({tag, ".sel"},     64'(bus.sel_o),          64'(m_sel));
      check({tag, ".cnt"},     64'(bus.conflict_cnt_o), 64'(m_cnt));
   endtask

   // One cycle: drive at negedge, check readies, clock, check registered write port.
   task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic st, input string tag, output int g);
      @(negedge clk);
      bus.req0_valid_i = v0; bus.req0_addr_i = a0; bus.req0_data_i = d0;
      bus.req1_valid_i = v1; bus.req1_addr_i = a1; bus.req1_data_i = d1;
      bus.stall_i = st;
      #1;
      if (st)            g = -1;
      else if (v0 && v1) g = 1 - m_last;
      else if (v0)       g = 0;
      else if (v1)       g = 1;
      else               g = -1;
      check({tag, ".ready0"}, 64'(bus.req0_ready_o), 64'(g == 0));
      check({tag, ".ready1"}, 64'(bus.req1_ready_o), 64'(g == 1));
      @(posedge clk);
      if (g >= 0) begin
         m_sel  = g;
         m_addr = (g == 0) ? a0 : a1;
         m_data = (g == 0) ? d0 : d1;
         m_en   = (m_addr != 0);
         m_last = g;
      end else begin
         m_en = 1'b0;
      end
      if (v0 && v1 && !st && m_cnt < CNT_SAT) m_cnt++;
      #1;
      check_outputs(tag);
   endtask

   // Asynchronous reset between clock edges, inputs left as they were.
   task automatic do_reset(input string tag);
      @(negedge clk);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs(tag);
      bus.req0_valid_i = 1'b0; bus.req1_valid_i = 1'b0; bus.stall_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int g;
      int grants[4];
      logic        p0, p1;
      logic [4:0]  pa0, pa1;
      logic [31:0] pd0, pd1;

      bus.stall_i = 1'b0;
      bus.req0_valid_i = 1'b0; bus.req0_addr_i = '0; bus.req0_data_i = '0;
      bus.req1_valid_i = 1'b0; bus.req1_addr_i = '0; bus.req1_data_i = '0;
      model_reset();
      repeat (2) @(negedge clk);
      #1 check_outputs("por");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, "idle", g);

      step(1, 5'd3, 32'hDEADBEEF, 0, 0, 0, 0, "single0", g);
      check("single0.data", 64'(bus.wr_data_o), 64'hDEADBEEF);
      step(0, 0, 0, 0, 0, 0, 0, "single0.after", g);

      do_reset("rst1");
      for (int i = 0; i < 4; i++) begin
         step(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, "alt", g);
         grants[i] = g;
      end
      for (int i = 0; i < 4; i++) check("alt.order", 64'(grants[i]), 64'(i % 2));
      check("alt.cnt", 64'(bus.conflict_cnt_o), 64'd4);

      do_reset("rst2");
      for (int i = 0; i < 3; i++) step(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 1, "stall", g);
      step(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, "unstall", g);
      check("unstall.grant", 64'(g), 64'd0);

      do_reset("rst3");
      step(0, 0, 0, 1, 5'd0, 32'h55, 0, "reg0", g);
      check("reg0.wr_en", 64'(bus.wr_en_o), 64'd0);
      step(1, 5'd7, 32'h77, 1, 5'd8, 32'h88, 0, "reg0.conflict", g);
      check("reg0.conflict.grant", 64'(g), 64'd0);

      for (int i = 0; i < 300; i++)
         step(1, 5'(i), 32'(i), 1, 5'(i + 1), 32'(~i), 0, "sat", g);
      check("sat.cnt", 64'(bus.conflict_cnt_o), 64'(CNT_SAT));
      do_reset("rst_mid");

      // Random requesters that hold each request until it is accepted.
      p0 = 1'b0; p1 = 1'b0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
      for (int i = 0; i < 400; i++) begin
         if (!p0 && $urandom_range(0, 2) != 0) begin
            p0 = 1'b1;
            pa0 = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            pd0 = $urandom;
         end
         if (!p1 && $urandom_range(0, 2) != 0) begin
            p1 = 1'b1;
            pa1 = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            pd1 = $urandom;
         end
         step(p0, pa0, pd0, p1, pa1, pd1, 1'($urandom_range(0, 4) == 0), "rand", g);
         if (g == 0) p0 = 1'b0;
         if (g == 1) p1 = 1'b0;
         if (i == 200) begin
            do_reset("rand.rst");
            p0 = 1'b0; p1 = 1'b0;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
